// File: rtl/request_unit.sv
// Request unit: turns decoded control-unit strobes into held memory requests,
// drives the PC enable and halt flag, and counts stalled cycles for accounting.
//
// state  | meaning
// FETCH  | instruction fetch; waiting for ihit
// DATA   | load/store outstanding; dREN/dWEN held until dhit
// HALTED | HALT retired; absorbing until reset
module request_unit #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   cuIRE,
  input  logic                   cuDRE,
  input  logic                   cuDWE,
  input  logic                   cuHALT,
  input  logic                   ihit,
  input  logic                   dhit,
  output logic                   iREN,
  output logic                   dREN,
  output logic                   dWEN,
  output logic                   pcEN,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       dren_nxt;
  logic       dwen_nxt;
  logic       halt_nxt;
  logic       stall_inc;

  // Gating with the state decode first keeps iREN at 0 in HALTED even if cuIRE is X.
  assign iREN = (state == FETCH) & cuIRE;

  always_comb begin
    pcEN = 1'b0;
    case (state)
      FETCH:   pcEN = ihit & ~cuDRE & ~cuDWE & ~cuHALT;
      DATA:    pcEN = dhit;
      default: pcEN = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    dren_nxt  = dREN;
    dwen_nxt  = dWEN;
    halt_nxt  = halt;
    case (state)
      FETCH: begin
        dren_nxt = 1'b0;
        dwen_nxt = 1'b0;
        if (ihit) begin
          if (cuHALT) begin
            state_nxt = HALTED;
            halt_nxt  = 1'b1;
          end else if (cuDRE | cuDWE) begin
            state_nxt = DATA;
            dren_nxt  = cuDRE;
            dwen_nxt  = cuDWE & ~cuDRE;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          state_nxt = FETCH;
          dren_nxt  = 1'b0;
          dwen_nxt  = 1'b0;
        end
      end
      HALTED: begin
        halt_nxt = 1'b1;
        dren_nxt = 1'b0;
        dwen_nxt = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
        dren_nxt  = 1'b0;
        dwen_nxt  = 1'b0;
      end
    endcase
  end

  assign stall_inc = (state != HALTED) & ~pcEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= FETCH;
      dREN        <= 1'b0;
      dWEN        <= 1'b0;
      halt        <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      dREN  <= dren_nxt;
      dWEN  <= dwen_nxt;
      halt  <= halt_nxt;
      if (stall_inc && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: a 32-bit and a 4-bit counter instance share stimulus;
// per-cycle expectations are queued as stimulus is driven and compared mid-cycle.
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST, cuIRE, cuDRE, cuDWE, cuHALT, ihit, dhit;
  logic        iREN, dREN, dWEN, pcEN, halt;
  logic        iREN_n, dREN_n, dWEN_n, pcEN_n, halt_n;
  logic [31:0] stall_count;
  logic [3:0]  stall_count_n;

  typedef struct {
    logic [4:0]  f;   // {iREN,dREN,dWEN,pcEN,halt}
    logic [31:0] s;
    logic [3:0]  s4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  request_unit #(.STALL_CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .cuIRE(cuIRE), .cuDRE(cuDRE), .cuDWE(cuDWE),
    .cuHALT(cuHALT), .ihit(ihit), .dhit(dhit), .iREN(iREN), .dREN(dREN),
    .dWEN(dWEN), .pcEN(pcEN), .halt(halt), .stall_count(stall_count)
  );

  request_unit #(.STALL_CNT_W(4)) dut_n (
    .CLK(CLK), .nRST(nRST), .cuIRE(cuIRE), .cuDRE(cuDRE), .cuDWE(cuDWE),
    .cuHALT(cuHALT), .ihit(ihit), .dhit(dhit), .iREN(iREN_n), .dREN(dREN_n),
    .dWEN(dWEN_n), .pcEN(pcEN_n), .halt(halt_n), .stall_count(stall_count_n)
  );

  always #5 CLK = ~CLK;

  // stimulus bits: {nRST,cuIRE,cuDRE,cuDWE,cuHALT,ihit,dhit}
  task automatic apply(input logic [6:0] st);
    {nRST, cuIRE, cuDRE, cuDWE, cuHALT, ihit, dhit} = st;
  endtask

  task automatic push_exp(input logic [4:0] f, input int s);
    exp_t e;
    e.f  = f;
    e.s  = 32'(s);
    e.s4 = (s > 15) ? 4'd15 : 4'(s);
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] st [2] = '{7'b0110010, 7'b0110010};
    exp_t e;
    apply(7'b0110010);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      push_exp(5'b10000, 0);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL reset[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL reset[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  task automatic test_alu_stream();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      apply(7'b1100010);
      push_exp(5'b10010, 0);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL alu[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL alu[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  task automatic test_load();
    logic [6:0] st [5] = '{7'b1110010, 7'b1101110, 7'b1100000, 7'b1100001, 7'b1100010};
    logic [4:0] ef [5] = '{5'b10000, 5'b01000, 5'b01000, 5'b01010, 5'b10010};
    int         es [5] = '{0, 1, 2, 3, 3};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      push_exp(ef[i], es[i]);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL load[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL load[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  task automatic test_store();
    logic [6:0] st [8] = '{7'b1111010, 7'b1100001, 7'b1101010, 7'b1100000,
                           7'b1100001, 7'b1100010, 7'b1100001, 7'b1100010};
    logic [4:0] ef [8] = '{5'b10000, 5'b01010, 5'b10000, 5'b00100,
                           5'b00110, 5'b10010, 5'b10000, 5'b10010};
    int         es [8] = '{3, 4, 4, 5, 6, 6, 6, 7};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      push_exp(ef[i], es[i]);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL store[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL store[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    logic [6:0] st [7] = '{7'b1101110, 7'b1100010, 7'b1000001, 7'b1xxxxxx,
                           7'b1111111, 7'b0100010, 7'b1100010};
    logic [4:0] ef [7] = '{5'b10000, 5'b00001, 5'b00001, 5'b00001,
                           5'b00001, 5'b00001, 5'b10010};
    int         es [7] = '{7, 8, 8, 8, 8, 8, 0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      apply(st[i]);
      push_exp(ef[i], es[i]);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL halt[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL halt[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_in_data();
    logic [6:0] st [3] = '{7'b1110010, 7'b0100000, 7'b1100000};
    logic [4:0] ef [3] = '{5'b10000, 5'b01000, 5'b10000};
    int         es [3] = '{0, 1, 0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      push_exp(ef[i], es[i]);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN, dREN, dWEN, pcEN, halt} !== e.f) begin
        errors++;
        $display("FAIL rst_data[%0d] flags: got %b expected %b", i, {iREN, dREN, dWEN, pcEN, halt}, e.f);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL rst_data[%0d] stall_count: got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  // Counter left at 1 by the previous test; reset, then stall 22 cycles.
  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 23; i++) begin
      if (i == 0) begin
        apply(7'b0100000);
        push_exp(5'b10000, 1);
      end else begin
        apply(7'b1100000);
        push_exp(5'b10000, i - 1);
      end
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if ({iREN_n, dREN_n, dWEN_n, pcEN_n, halt_n} !== e.f) begin
        errors++;
        $display("FAIL sat[%0d] flags: got %b expected %b", i, {iREN_n, dREN_n, dWEN_n, pcEN_n, halt_n}, e.f);
      end
      checks++;
      if (stall_count_n !== e.s4) begin
        errors++;
        $display("FAIL sat[%0d] stall_count(4b): got %0d expected %0d", i, stall_count_n, e.s4);
      end
      checks++;
      if (stall_count !== e.s) begin
        errors++;
        $display("FAIL sat[%0d] stall_count(32b): got %0d expected %0d", i, stall_count, e.s);
      end
      next_cycle();
    end
  endtask

  initial begin
    apply(7'b0000000);
    test_reset();
    test_alu_stream();
    test_load();
    test_store();
    test_halt();
    test_reset_in_data();
    test_saturation();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
